// File: rtl/toom_pkg.sv
// Shared definitions for the Toom-K evaluation datapath: width helpers,
// point-index decoding and the streaming FSM state type.
package toom_pkg;

  // Streaming controller states.
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } toom_state_t;

  // Decoded evaluation point. Finite points are +/-2^j; j is meaningful
  // only when neither is_zero nor is_inf is set.
  typedef struct packed {
    logic [15:0] j;
    logic        neg;
    logic        is_zero;
    logic        is_inf;
  } toom_pt_t;

  // Signed evaluation width: enough headroom for the largest |X(2^(K-2))|.
  function automatic int toom_ew(input int k, input int w);
    return w + (k - 2) * (k - 1) + 2;
  endfunction

  // Width of a point index covering 0..2K-2.
  function automatic int toom_iw(input int k);
    return $clog2(2 * k - 1);
  endfunction

  // Index 0 is the point p=0.
  function automatic logic toom_pt_zero(input int idx);
    return idx == 0;
  endfunction

  // The last index is the point at infinity.
  function automatic logic toom_pt_inf(input int idx, input int k);
    return idx == 2 * k - 2;
  endfunction

  // Even, non-zero, finite indices are the negative points.
  function automatic logic toom_pt_neg(input int idx, input int k);
    return (idx != 0) && (idx != 2 * k - 2) && ((idx % 2) == 0);
  endfunction

  // Exponent j of the point +/-2^j carried by a finite index.
  function automatic int toom_pt_j(input int idx, input int k);
    if (toom_pt_zero(idx) || toom_pt_inf(idx, k)) return 0;
    return (idx - 1) / 2;
  endfunction

  // Index of the point +2^j (neg=0) or -2^j (neg=1).
  function automatic int toom_encode(input int j, input logic neg);
    return 2 * j + 1 + (neg ? 1 : 0);
  endfunction

  // Full decode of a point index into its fields.
  function automatic toom_pt_t toom_decode(input int idx, input int k);
    toom_pt_t pt;
    pt.j       = 16'(toom_pt_j(idx, k));
    pt.neg     = toom_pt_neg(idx, k);
    pt.is_zero = toom_pt_zero(idx);
    pt.is_inf  = toom_pt_inf(idx, k);
    return pt;
  endfunction

endpackage

// File: rtl/toom_eo_sum.sv
// Even/odd partial sums of a K-limb operand at shift j:
//   E_j = sum over even i of a_i * 2^(i*j)
//   O_j = sum over odd  i of a_i * 2^(i*j)
// Pure shifts and adds; all terms are non-negative so they fit EW bits.
module toom_eo_sum
  import toom_pkg::*;
#(
  parameter int K  = 8,
  parameter int W  = 128,
  parameter int EW = toom_ew(K, W),
  parameter int IW = toom_iw(K)
) (
  input  logic [K*W-1:0]       i_limbs,
  input  logic [IW-1:0]        i_j,
  output logic signed [EW-1:0] o_e,
  output logic signed [EW-1:0] o_o
);

  logic [EW-1:0] w_term;
  logic [EW-1:0] w_e;
  logic [EW-1:0] w_o;

  // Shift every limb by i*j and accumulate into the even or odd sum.
  always_comb begin
    // NOTE: every variable gets a value before any conditional path so no latch is inferred.
    w_term = '0;
    w_e    = '0;
    w_o    = '0;
    for (int i = 0; i < K; i++) begin
      w_term = EW'(i_limbs[i*W +: W]) << (i * int'(i_j));
      if ((i % 2) == 0) w_e = w_e + w_term;
      else              w_o = w_o + w_term;
    end
  end

  assign o_e = w_e;
  assign o_o = w_o;

endmodule

// File: rtl/toom_eval_stream.sv
// Toom-K evaluation engine. Accepts an operand pair (X, Y) and streams
// X(p), Y(p) for the 2K-1 points 0, +1, -1, +2, -2, ..., +2^(K-2), inf,
// one point per valid/ready beat. The next beat is computed one cycle
// ahead into the output registers, so a continuously ready sink sees no
// bubbles. E_j/O_j are captured on each +2^j beat and reused for -2^j.
module toom_eval_stream
  import toom_pkg::*;
#(
  parameter int  K  = 8,
  parameter int  W  = 128,
  localparam int EW = toom_ew(K, W),
  localparam int IW = toom_iw(K)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [K*W-1:0]       x,
  input  logic [K*W-1:0]       y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IW-1:0]        out_idx,
  output logic signed [EW-1:0] out_a,
  output logic signed [EW-1:0] out_b,
  output logic                 out_last
);

  localparam logic [IW-1:0] LAST_IDX = IW'(2 * K - 2);

  // Controller and output registers.
  toom_state_t          r_state;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic                 r_out_last;
  logic [IW-1:0]        r_out_idx;
  logic signed [EW-1:0] r_out_a;
  logic signed [EW-1:0] r_out_b;

  // Operand and held partial-sum registers.
  logic [K*W-1:0]       r_x;
  logic [K*W-1:0]       r_y;
  logic signed [EW-1:0] r_e_a;
  logic signed [EW-1:0] r_o_a;
  logic signed [EW-1:0] r_e_b;
  logic signed [EW-1:0] r_o_b;

  logic                 w_accept;
  logic                 w_advance;
  logic [IW-1:0]        w_nidx;
  logic [IW-1:0]        w_j;
  logic                 w_zero;
  logic                 w_inf;
  logic                 w_neg;
  logic signed [EW-1:0] w_e_a;
  logic signed [EW-1:0] w_o_a;
  logic signed [EW-1:0] w_e_b;
  logic signed [EW-1:0] w_o_b;
  logic signed [EW-1:0] w_nxt_a;
  logic signed [EW-1:0] w_nxt_b;

  assign w_accept  = (r_state == ST_IDLE) && in_valid;
  assign w_advance = (r_state == ST_STREAM) && out_ready;

  // Index of the beat that will be loaded into the output registers next.
  // In IDLE that is always the first point, taken straight from the input.
  assign w_nidx = (r_state == ST_IDLE) ? '0 : r_out_idx + IW'(1);

  assign w_zero = toom_pt_zero(int'(w_nidx));
  assign w_inf  = toom_pt_inf(int'(w_nidx), K);
  assign w_neg  = toom_pt_neg(int'(w_nidx), K);
  assign w_j    = IW'(toom_pt_j(int'(w_nidx), K));

  toom_eo_sum #(.K(K), .W(W), .EW(EW), .IW(IW)) u_eo_a (
    .i_limbs (r_x),
    .i_j     (w_j),
    .o_e     (w_e_a),
    .o_o     (w_o_a)
  );

  toom_eo_sum #(.K(K), .W(W), .EW(EW), .IW(IW)) u_eo_b (
    .i_limbs (r_y),
    .i_j     (w_j),
    .o_e     (w_e_b),
    .o_o     (w_o_b)
  );

  // Select the value of the next beat from the point kind.
  always_comb begin
    w_nxt_a = '0;
    w_nxt_b = '0;
    if (w_zero) begin
      w_nxt_a = EW'(x[W-1:0]);
      w_nxt_b = EW'(y[W-1:0]);
    end else if (w_inf) begin
      w_nxt_a = EW'(r_x[(K-1)*W +: W]);
      w_nxt_b = EW'(r_y[(K-1)*W +: W]);
    end else if (w_neg) begin
      w_nxt_a = r_e_a - r_o_a;
      w_nxt_b = r_e_b - r_o_b;
    end else begin
      w_nxt_a = w_e_a + w_o_a;
      w_nxt_b = w_e_b + w_o_b;
    end
  end

  // Handshake FSM with registered outputs; reset wins over any handshake.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_idx   <= '0;
      r_out_a     <= '0;
      r_out_b     <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state     <= ST_STREAM;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b1;
            r_out_idx   <= w_nidx;
            r_out_a     <= w_nxt_a;
            r_out_b     <= w_nxt_b;
            r_out_last  <= 1'b0;
          end
        end
        ST_STREAM: begin
          if (w_advance) begin
            if (r_out_last) begin
              r_state     <= ST_IDLE;
              r_in_ready  <= 1'b1;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
            end else begin
              r_out_idx  <= w_nidx;
              r_out_a    <= w_nxt_a;
              r_out_b    <= w_nxt_b;
              r_out_last <= (w_nidx == LAST_IDX);
            end
          end
        end
      endcase
    end
  end

  // Operand capture and E/O hold for the following negative point.
  always_ff @(posedge clk) begin
    // NOTE: pure data registers carry no reset; the FSM never reads them before they are loaded.
    if (w_accept) begin
      r_x <= x;
      r_y <= y;
    end
    if (w_advance && !r_out_last && !w_zero && !w_inf && !w_neg) begin
      r_e_a <= w_e_a;
      r_o_a <= w_o_a;
      r_e_b <= w_e_b;
      r_o_b <= w_o_b;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_idx   = r_out_idx;
  assign out_a     = r_out_a;
  assign out_b     = r_out_b;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_toom_eval_stream.sv
// Bench for toom_eval_stream: one K=8/W=128 instance and one K=3/W=4
// instance. Expected beats come from direct polynomial evaluation
// (Horner's rule at p = +/-2^j) rather than even/odd sums.
module tb_toom_eval_stream;
  import toom_pkg::*;

  localparam int EW8 = toom_ew(8, 128);
  localparam int IW8 = toom_iw(8);
  localparam int EW3 = toom_ew(3, 4);
  localparam int IW3 = toom_iw(3);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   sel = 8;
  int   cyc = 0;

  logic          tb_in_valid  = 1'b0;
  logic          tb_out_ready = 1'b1;
  logic [1023:0] tb_x = '0;
  logic [1023:0] tb_y = '0;

  logic                  iv8, ir8, ov8, or8, ol8;
  logic [IW8-1:0]        oi8;
  logic signed [EW8-1:0] oa8, ob8;
  logic                  iv3, ir3, ov3, or3, ol3;
  logic [IW3-1:0]        oi3;
  logic signed [EW3-1:0] oa3, ob3;

  assign iv8 = tb_in_valid && (sel == 8);
  assign or8 = (sel == 8) ? tb_out_ready : 1'b1;
  assign iv3 = tb_in_valid && (sel == 3);
  assign or3 = (sel == 3) ? tb_out_ready : 1'b1;

  toom_eval_stream #(.K(8), .W(128)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
    .x(tb_x), .y(tb_y), .out_valid(ov8), .out_ready(or8),
    .out_idx(oi8), .out_a(oa8), .out_b(ob8), .out_last(ol8)
  );

  toom_eval_stream #(.K(3), .W(4)) dut3 (
    .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3),
    .x(tb_x[11:0]), .y(tb_y[11:0]), .out_valid(ov3), .out_ready(or3),
    .out_idx(oi3), .out_a(oa3), .out_b(ob3), .out_last(ol3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // View of the currently selected instance.
  logic signed [255:0] a8x, b8x, a3x, b3x, v_a, v_b;
  logic v_valid, v_in_ready, v_last;
  int   v_idx;
  assign a8x = oa8;
  assign b8x = ob8;
  assign a3x = oa3;
  assign b3x = ob3;
  assign v_a        = (sel == 3) ? a3x : a8x;
  assign v_b        = (sel == 3) ? b3x : b8x;
  assign v_valid    = (sel == 3) ? ov3 : ov8;
  assign v_in_ready = (sel == 3) ? ir3 : ir8;
  assign v_last     = (sel == 3) ? ol3 : ol8;
  assign v_idx      = (sel == 3) ? int'(oi3) : int'(oi8);

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string name, input logic signed [255:0] act, input logic signed [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: point for index idx, then Horner evaluation of the operand.
  function automatic logic signed [255:0] ref_eval(input int k, input int w, input logic [1023:0] op, input int idx);
    logic [1023:0]       mask;
    logic signed [255:0] acc, p, limb;
    int                  j;
    mask = (1024'd1 << w) - 1024'd1;
    if (idx == 0) return 256'(op & mask);
    if (idx == 2 * k - 2) return 256'((op >> ((k - 1) * w)) & mask);
    j = (idx - 1) / 2;
    p = 256'sd1 <<< j;
    if ((idx % 2) == 0) p = -p;
    acc = '0;
    for (int i = k - 1; i >= 0; i--) begin
      limb = 256'((op >> (i * w)) & mask);
      acc  = acc * p + limb;
    end
    return acc;
  endfunction

  function automatic logic [1023:0] mk_op(input int k, input int w, input logic [63:0] limbs);
    logic [1023:0] op;
    op = '0;
    for (int i = 0; i < k; i++) op = op | (1024'(limbs[i*8 +: 8]) << (i * w));
    return op;
  endfunction

  function automatic logic [1023:0] rand_op(input int k, input int w);
    logic [1023:0] op;
    for (int i = 0; i < 32; i++) op[i*32 +: 32] = $urandom();
    return op & ((1024'd1 << (k * w)) - 1024'd1);
  endfunction

  // Present an operand pair once in_ready is seen; returns on the cycle
  // where the first beat should be visible.
  task automatic send(input logic [1023:0] xo, input logic [1023:0] yo, input bit hold);
    int n;
    n = 0;
    while (!v_in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!v_in_ready) check_bit("send in_ready timeout", v_in_ready, 1'b1);
    tb_x        = xo;
    tb_y        = yo;
    tb_in_valid = 1'b1;
    @(negedge clk);
    if (!hold) tb_in_valid = 1'b0;
  endtask

  // Follow the beat stream from index start, checking every cycle against
  // the model. Stops when index stop_at is showing, or after the last
  // handshake (then checks the block is idle again).
  task automatic consume(input string tag, input logic [1023:0] xo, input logic [1023:0] yo,
                         input bit bp, input int start, input int stop_at, input int cap_idx,
                         output logic signed [255:0] cap_a, output logic signed [255:0] cap_b);
    int k, w, n, idx, cycles;
    k = sel;
    w = (sel == 3) ? 4 : 128;
    n = 2 * k - 1;
    idx = start;
    cycles = 0;
    cap_a = '0;
    cap_b = '0;
    forever begin
      check_bit($sformatf("%s idx%0d out_valid", tag, idx), v_valid, 1'b1);
      check_bit($sformatf("%s idx%0d in_ready", tag, idx), v_in_ready, 1'b0);
      check_int($sformatf("%s out_idx", tag), v_idx, idx);
      check_val($sformatf("%s idx%0d out_a", tag, idx), v_a, ref_eval(k, w, xo, idx));
      check_val($sformatf("%s idx%0d out_b", tag, idx), v_b, ref_eval(k, w, yo, idx));
      check_bit($sformatf("%s idx%0d out_last", tag, idx), v_last, idx == n - 1);
      if (idx == cap_idx) begin
        cap_a = v_a;
        cap_b = v_b;
      end
      if (idx == stop_at) break;
      tb_out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tb_out_ready) idx++;
      @(negedge clk);
      cycles++;
      if (idx == n) begin
        check_bit($sformatf("%s done out_valid", tag), v_valid, 1'b0);
        check_bit($sformatf("%s done in_ready", tag), v_in_ready, 1'b1);
        break;
      end
      if (cycles > 400) begin
        check_int($sformatf("%s stream timeout", tag), idx, n);
        break;
      end
    end
    tb_out_ready = 1'b1;
  endtask

  typedef struct {
    int          k;
    logic [63:0] limbs;
    int          idx;
    int          expv;
  } vec_t;

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vec_t                vecs[13];
    logic signed [255:0] ca, cb;
    logic [1023:0]       op_a, op_b, basic;
    int                  t0, t1;

    vecs[0]  = '{8, 64'h08070605040302FD, 0, 253};
    vecs[1]  = '{8, 64'h08070605040302FD, 1, 288};
    vecs[2]  = '{8, 64'h08070605040302FD, 2, 248};
    vecs[3]  = '{8, 64'h08070605040302FD, 3, 2045};
    vecs[4]  = '{8, 64'h08070605040302FD, 4, -459};
    vecs[5]  = '{8, 64'h08070605040302FD, 14, 8};
    vecs[6]  = '{3, 64'h0F0F0F, 0, 15};
    vecs[7]  = '{3, 64'h0F0F0F, 1, 45};
    vecs[8]  = '{3, 64'h0F0F0F, 2, 15};
    vecs[9]  = '{3, 64'h0F0F0F, 3, 105};
    vecs[10] = '{3, 64'h0F0F0F, 4, 15};
    vecs[11] = '{3, 64'h0F000F, 2, 30};
    vecs[12] = '{3, 64'h000F00, 2, -15};
    basic = mk_op(8, 128, 64'h08070605040302FD);

    // Reset state of both instances.
    repeat (3) @(negedge clk);
    check_bit("rst in_ready8", ir8, 1'b1);
    check_bit("rst out_valid8", ov8, 1'b0);
    check_bit("rst out_last8", ol8, 1'b0);
    check_int("rst out_idx8", int'(oi8), 0);
    check_val("rst out_a8", a8x, 256'sd0);
    check_val("rst out_b8", b8x, 256'sd0);
    check_bit("rst in_ready3", ir3, 1'b1);
    check_bit("rst out_valid3", ov3, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Directed values from the table.
    for (int r = 0; r < 13; r++) begin
      sel  = vecs[r].k;
      op_a = mk_op(sel, (sel == 3) ? 4 : 128, vecs[r].limbs);
      send(op_a, op_a, 1'b0);
      consume($sformatf("vec%0d", r), op_a, op_a, 1'b0, 0, -1, vecs[r].idx, ca, cb);
      check_val($sformatf("vec%0d table a", r), ca, 256'(vecs[r].expv));
      check_val($sformatf("vec%0d table b", r), cb, 256'(vecs[r].expv));
    end

    // Backpressure on the basic operand.
    sel = 8;
    for (int r = 0; r < 3; r++) begin
      send(basic, basic, 1'b0);
      consume("bp basic", basic, basic, 1'b1, 0, -1, -1, ca, cb);
    end

    // Random operands, both sizes, random backpressure.
    sel = 3;
    for (int r = 0; r < 150; r++) begin
      op_a = rand_op(3, 4);
      op_b = rand_op(3, 4);
      send(op_a, op_b, 1'b0);
      consume("rand k3", op_a, op_b, 1'($urandom_range(0, 1)), 0, -1, -1, ca, cb);
    end
    sel = 8;
    for (int r = 0; r < 20; r++) begin
      op_a = rand_op(8, 128);
      op_b = rand_op(8, 128);
      send(op_a, op_b, 1'b0);
      consume("rand k8", op_a, op_b, 1'($urandom_range(0, 1)), 0, -1, -1, ca, cb);
    end

    // Reset while idx 5 is on the output.
    send(basic, basic, 1'b0);
    consume("pre-reset", basic, basic, 1'b0, 0, 5, -1, ca, cb);
    rst = 1'b1;
    @(negedge clk);
    check_bit("midrst out_valid", ov8, 1'b0);
    check_bit("midrst in_ready", ir8, 1'b1);
    check_bit("midrst out_last", ol8, 1'b0);
    check_int("midrst out_idx", int'(oi8), 0);
    check_val("midrst out_a", a8x, 256'sd0);
    rst = 1'b0;
    op_a = rand_op(8, 128);
    send(op_a, op_a, 1'b0);
    consume("post-reset", op_a, op_a, 1'b0, 0, -1, -1, ca, cb);

    // A second operand offered mid-stream waits until IDLE.
    op_b = rand_op(8, 128);
    send(basic, basic, 1'b0);
    consume("busy first", basic, basic, 1'b0, 0, 3, -1, ca, cb);
    tb_x        = op_b;
    tb_y        = op_b;
    tb_in_valid = 1'b1;
    consume("busy first", basic, basic, 1'b1, 3, -1, -1, ca, cb);
    @(negedge clk);
    tb_in_valid = 1'b0;
    consume("busy second", op_b, op_b, 1'b0, 0, -1, -1, ca, cb);

    // Back-to-back with in_valid held: idx 0 beats 2K cycles apart.
    send(basic, basic, 1'b1);
    t0 = cyc;
    consume("b2b first", basic, basic, 1'b0, 0, -1, -1, ca, cb);
    @(negedge clk);
    t1 = cyc;
    check_int("b2b idx0 spacing", t1 - t0, 16);
    tb_in_valid = 1'b0;
    consume("b2b second", basic, basic, 1'b0, 0, -1, -1, ca, cb);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
